multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control state machine for the multi-cycle RV32I core.
- Sequences one shared ALU, one unified instruction/data memory port and the register file across fetch, decode, execute, memory and writeback steps.
- Drives `alu_op` into the existing ALU decoder and all datapath mux selects and write strobes.
- Owns the memory wait handshake and a bus-timeout trap.

## Interface
- `WAIT_LIMIT`, default 16: max cycles `mem_req` may wait for `mem_ready` before trapping; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `op_code`  in  7  `instr[6:0]` from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `mem_write`  out  1  access is a store; valid with `mem_req`.
- `adr_src`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR and OldPC.
- `pc_write`  out  1  load PC.
- `reg_write`  out  1  register-file write.
- `alu_src_a`  out  2  operand A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b`  out  2  operand B select: 00 = rs2, 01 = imm, 10 = const 4.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = decode funct fields.
- `result_src`  out  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `trap`  out  1  sticky error flag.
- `trap_cause`  out  2  00 = none, 01 = illegal opcode, 10 = bus timeout.

## Operation
- The FSM is Moore-style: every strobe and select is decoded from state only, except that `pc_write`, `ir_write` and `instr_done` are also qualified by `zero` or `mem_ready`.
- Default outputs when not listed: all 0.
- FETCH:
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - On `mem_ready`: `ir_write`=1 and `pc_write`=1, go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target).
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; any other opcode → TRAP with cause 01.
- MEMADR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - Next: MEMREAD if `op_code[5]`=0, else MEMWRITE.
- MEMREAD:
  - Outputs: `mem_req`=1, `adr_src`=1, `result_src`=00.
  - On `mem_ready` → MEMWB.
- MEMWB:
  - Outputs: `result_src`=01, `reg_write`=1, `instr_done`=1.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: `mem_req`=1, `mem_write`=1, `adr_src`=1.
  - On `mem_ready`: `instr_done`=1, go to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10; next ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10; next ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1; next FETCH.
- BEQ:
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `instr_done`=1.
  - `pc_write`=`zero`.
  - Next: FETCH.
- JAL:
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1.
  - Next: ALUWB (writes PC+4 to rd).
- TRAP:
  - All strobes 0, `trap`=1.
  - Terminal; only `rst` exits.
- `imm_src` is combinational from `op_code`, valid in every state:
  - I for 0000011 and 0010011, S for 0100011, B for 1100011, J for 1101111, 00 for all others.
- Wait counter:
  - Cleared on entry to any `mem_req` state; increments each cycle with `mem_req`=1 and `mem_ready`=0.
  - When `WAIT_LIMIT`≠0 and the count reaches `WAIT_LIMIT`, the FSM goes to TRAP with cause 10 and `mem_req` drops next cycle.
  - A `mem_ready` arriving on that same cycle wins: the access completes and no trap is raised.

## Timing
- Reset:
  - While `rst`=1, state is FETCH, the wait counter is 0, `trap`/`trap_cause` are 0, and all strobes are forced 0.
  - FETCH outputs appear the cycle after `rst` deasserts.
  - A reset asserted mid-instruction aborts it at the next edge; no write strobe fires in the reset cycle.
- Latency with `mem_ready` tied high, counted in cycles from FETCH entry to `instr_done`:
  - lw 5, sw 4, R 4, I 4, beq 3, jal 4.
  - Each wait cycle adds 1.
- `mem_req` and `mem_write` stay stable until `mem_ready`.
- The memory samples the address and data on the `mem_ready` cycle.
- `instr_done` is never asserted in TRAP or during reset.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - `state_t` enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
  - Opcode localparams.
  - Enums for `alu_op`, `alu_src_a`, `alu_src_b`, `result_src`, `imm_src` and `trap_cause`.
- One sub-module: `mem_wait_timer` (counter plus timeout compare, parameterised by `WAIT_LIMIT`).
- The ALU decoder stays outside this block and consumes `alu_op`.

## Test plan
- Reset held 3 cycles mid-EXECR, then released → state FETCH, `reg_write` never pulses, `mem_req`=1 on the first cycle after release.
- `add` (0110011) with `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB; `alu_op`=10 in EXECR; `reg_write` and `instr_done` pulse on cycle 4.
- `lw` with 2 wait cycles in FETCH and 1 in MEMREAD → 8 cycles total; `ir_write` on cycle 3 only; `result_src`=01 with `reg_write` on the final cycle.
- `beq` with `zero`=1, then with `zero`=0 → `pc_write`=1 in BEQ for the first and 0 for the second; 3 cycles each.
- Opcode 0000000 → TRAP after DECODE, `trap_cause`=01, `trap` stays 1 for 20 cycles, no `mem_req`.
- `WAIT_LIMIT`=4 with `mem_ready` held 0 in MEMWRITE → TRAP with `trap_cause`=10 after 4 wait cycles; a repeat with `mem_ready`=1 on the 4th wait cycle completes the store with no trap.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and opcodes for the multi-cycle RV32I control path
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} alu_src_a_t;
    typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} result_src_t;
    typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
    typedef enum logic [1:0] {CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10} trap_cause_t;

    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags a bus timeout
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic timeout
);
    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] count;

    // Saturates at the limit so a disabled or ignored timeout never wraps
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (waiting && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (WAIT_LIMIT != 0) && waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);
    state_t      state, state_next;
    trap_cause_t cause_q, cause_next;
    logic        in_mem_state;
    logic        timeout;

    assign in_mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);

    // Cleared whenever no access is pending or one completes, so each access starts at 0
    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_mem_state || mem_ready),
        .waiting (in_mem_state && !mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        cause_next = cause_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op_code)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BEQ;
                    OP_JAL:            state_next = JAL;
                    default: begin
                        state_next = TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = op_code[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_FUNCT;
                state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_SUB;
                instr_done = 1'b1;
                pc_write   = zero;
                state_next = FETCH;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            TRAP: state_next = TRAP;
            default: state_next = FETCH;
        endcase
        // Reset overrides everything so an aborted instruction cannot write
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALU_ADD;
            result_src = RES_ALUOUT;
        end
    end

    assign trap       = !rst && (state == TRAP);
    assign trap_cause = rst ? CAUSE_NONE : cause_q;
    assign imm_src    = imm_src_of(op_code);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and randomized checks of multicycle_ctrl against a step-plan model
module tb_multicycle_ctrl;
    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [6:0] op_code;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src, trap_cause;

    multicycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src), .instr_done(instr_done),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    wire [14:0] obs_v = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done,
                         alu_src_a, alu_src_b, alu_op, result_src};

    int passed = 0;
    int failed = 0;
    int total  = 0;

    function automatic logic [14:0] o(input bit mr, mw, ad, irw, pcw, rw, dn,
                                      input logic [1:0] a, b, op, rs);
        return {mr, mw, ad, irw, pcw, rw, dn, a, b, op, rs};
    endfunction

    typedef struct {
        logic [14:0] base;
        logic [14:0] on_ready;
        bit          mem;
        bit          beq;
    } step_t;

    step_t plan[$];

    // Step table: outputs of each microstep taken straight from the operation rules
    localparam logic [14:0] S_FETCH  = 15'b100_0000_00_10_00_10;
    localparam logic [14:0] S_DECODE = 15'b000_0000_01_01_00_00;
    localparam logic [14:0] S_MEMADR = 15'b000_0000_10_01_00_00;
    localparam logic [14:0] S_MEMRD  = 15'b101_0000_00_00_00_00;
    localparam logic [14:0] S_MEMWB  = 15'b000_0011_00_00_00_01;
    localparam logic [14:0] S_MEMWR  = 15'b111_0000_00_00_00_00;
    localparam logic [14:0] S_EXECR  = 15'b000_0000_10_00_10_00;
    localparam logic [14:0] S_EXECI  = 15'b000_0000_10_01_10_00;
    localparam logic [14:0] S_ALUWB  = 15'b000_0011_00_00_00_00;
    localparam logic [14:0] S_BEQ    = 15'b000_0001_10_00_01_00;
    localparam logic [14:0] S_JAL    = 15'b000_0100_01_10_00_00;
    localparam logic [14:0] M_IRPC   = 15'b000_1100_00_00_00_00;
    localparam logic [14:0] M_PCW    = 15'b000_0100_00_00_00_00;
    localparam logic [14:0] M_DONE   = 15'b000_0001_00_00_00_00;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BR) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic add_step(input logic [14:0] base, input logic [14:0] rdy, input bit mem, input bit beq);
        step_t s;
        s.base = base; s.on_ready = rdy; s.mem = mem; s.beq = beq;
        plan.push_back(s);
    endtask

    task automatic build_plan(input logic [6:0] op);
        plan.delete();
        add_step(S_FETCH, M_IRPC, 1'b1, 1'b0);
        add_step(S_DECODE, '0, 1'b0, 1'b0);
        case (op)
            LW: begin add_step(S_MEMADR, '0, 0, 0); add_step(S_MEMRD, '0, 1, 0); add_step(S_MEMWB, '0, 0, 0); end
            SW: begin add_step(S_MEMADR, '0, 0, 0); add_step(S_MEMWR, M_DONE, 1, 0); end
            RT: begin add_step(S_EXECR, '0, 0, 0); add_step(S_ALUWB, '0, 0, 0); end
            IT: begin add_step(S_EXECI, '0, 0, 0); add_step(S_ALUWB, '0, 0, 0); end
            BR: add_step(S_BEQ, '0, 0, 1);
            JL: begin add_step(S_JAL, '0, 0, 0); add_step(S_ALUWB, '0, 0, 0); end
            default: ;
        endcase
    endtask

    // Inputs driven just after a rising edge, outputs compared 1 time unit later
    task automatic cycle(input string tag, input logic rdy, input logic [14:0] exp, input logic [2:0] exp_trap);
        mem_ready = rdy;
        #1;
        check(tag, 32'(obs_v), 32'(exp));
        check({tag, "_trap"}, 32'({trap, trap_cause}), 32'(exp_trap));
        check({tag, "_imm"}, 32'(imm_src), 32'(exp_imm(op_code)));
        @(posedge clk);
        #1;
    endtask

    task automatic rcycle(input string tag);
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check(tag, 32'(obs_v), 32'd0);
        check({tag, "_trap"}, 32'({trap, trap_cause}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int w_fetch, input int w_mem,
                             output int cycles);
        int nmem;
        build_plan(op);
        op_code = op;
        zero    = z;
        cycles  = 0;
        nmem    = 0;
        foreach (plan[i]) begin
            if (plan[i].mem) begin
                repeat ((nmem == 0) ? w_fetch : w_mem) begin
                    cycle("wait", 1'b0, plan[i].base, 3'b000);
                    cycles++;
                end
                cycle("mem_step", 1'b1, plan[i].base | plan[i].on_ready, 3'b000);
                nmem++;
            end else if (plan[i].beq) begin
                cycle("beq", 1'($urandom_range(0, 1)), plan[i].base | (z ? M_PCW : 15'd0), 3'b000);
            end else begin
                cycle("step", 1'($urandom_range(0, 1)), plan[i].base, 3'b000);
            end
            cycles++;
        end
    endtask

    logic [6:0] ops [6];
    int n;

    initial begin
        ops = '{LW, SW, RT, IT, BR, JL};
        rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; op_code = 7'd0;
        @(posedge clk); #1;
        rcycle("reset");
        rcycle("reset");
        rst = 1'b0;

        // Reset held 3 cycles starting in EXECR
        op_code = RT;
        cycle("pre_fetch", 1'b1, S_FETCH | M_IRPC, 3'b000);
        cycle("pre_decode", 1'b0, S_DECODE, 3'b000);
        rst = 1'b1;
        repeat (3) rcycle("mid_reset");
        rst = 1'b0;

        run_instr(RT, 1'b0, 0, 0, n); check("lat_add", n, 4);
        run_instr(LW, 1'b0, 2, 1, n); check("lat_lw_waits", n, 8);
        run_instr(LW, 1'b1, 0, 0, n); check("lat_lw", n, 5);
        run_instr(SW, 1'b0, 0, 0, n); check("lat_sw", n, 4);
        run_instr(IT, 1'b0, 0, 0, n); check("lat_i", n, 4);
        run_instr(BR, 1'b1, 0, 0, n); check("lat_beq_taken", n, 3);
        run_instr(BR, 1'b0, 0, 0, n); check("lat_beq_not", n, 3);
        run_instr(JL, 1'b0, 0, 0, n); check("lat_jal", n, 4);

        for (int k = 0; k < 40; k++) begin
            run_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), n);
        end

        // Store whose memory never answers: four counted waits, then the limit cycle traps
        op_code = SW;
        cycle("to_fetch", 1'b1, S_FETCH | M_IRPC, 3'b000);
        cycle("to_decode", 1'b0, S_DECODE, 3'b000);
        cycle("to_memadr", 1'b0, S_MEMADR, 3'b000);
        repeat (LIMIT + 1) cycle("to_wait", 1'b0, S_MEMWR, 3'b000);
        repeat (5) cycle("to_trap", 1'($urandom_range(0, 1)), 15'd0, 3'b110);
        rst = 1'b1;
        repeat (2) rcycle("to_reset");
        rst = 1'b0;

        // Same store, memory answers on the limit cycle: completes without trap
        run_instr(SW, 1'b0, 0, LIMIT, n); check("lat_sw_limit", n, 4 + LIMIT);
        run_instr(RT, 1'b0, 0, 0, n);

        // Illegal opcode traps after decode and stays there
        op_code = 7'b0000000;
        cycle("ill_fetch", 1'b1, S_FETCH | M_IRPC, 3'b000);
        cycle("ill_decode", 1'b0, S_DECODE, 3'b000);
        repeat (20) cycle("ill_trap", 1'($urandom_range(0, 1)), 15'd0, 3'b101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
